// File: rtl/regfile_pkg.sv
// Shared register-file definitions: bus widths, control encodings and sequencer states.
package regfile_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int REG_NUM      = 32;

    localparam logic [REG_BUS-1:0] ZERO_DWORD   = '0;
    localparam logic               WRITE_ENABLE = 1'b1;
    localparam logic               READ_ENABLE  = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks every register address once, then enters RUN.
// Clears exactly REG_NUM registers, one per cycle; ready rises on the edge that clears the last one.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NUM = regfile_pkg::REG_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    output state_t                  state,
    output logic [REG_ADDR_BUS-1:0] clr_addr,
    output logic                    clr_we,
    output logic                    ready_o
);

    logic [REG_ADDR_BUS-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == REG_ADDR_BUS'(NUM - 1)) begin
                        state   <= ST_RUN;
                        ready_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state   <= ST_RUN;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    clr_cnt <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    assign clr_addr = clr_cnt;
    assign clr_we   = (state == ST_INIT);

endmodule

// File: rtl/regfile.sv
// Two-read, one-write integer register file with a post-reset clear sweep.
// Optional same-cycle write forwarding when REGFILE_BYPASS_EN is defined; otherwise reads see the pre-write value.
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM = regfile_pkg::REG_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [REG_ADDR_BUS-1:0] waddr,
    input  logic [REG_BUS-1:0]      wdata,
    input  logic                    re1,
    input  logic [REG_ADDR_BUS-1:0] raddr1,
    output logic [REG_BUS-1:0]      rdata1,
    input  logic                    re2,
    input  logic [REG_ADDR_BUS-1:0] raddr2,
    output logic [REG_BUS-1:0]      rdata2,
    output logic                    ready_o
);

    state_t                  state;
    logic [REG_ADDR_BUS-1:0] clr_addr;
    logic                    clr_we;

    logic [REG_BUS-1:0]      regs [REG_NUM];

    logic                    wr_en;
    logic [REG_ADDR_BUS-1:0] wr_addr;
    logic [REG_BUS-1:0]      wr_data;

    regfile_clr_seq #(.NUM(REG_NUM)) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .ready_o  (ready_o)
    );

    // The sweep owns the single write port during INIT; external writes are dropped then.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = wdata;
        if (!rst) begin
            if (clr_we) begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = ZERO_DWORD;
            end else if (we == WRITE_ENABLE && waddr != '0) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            regs[wr_addr] <= wr_data;
    end

    function automatic logic [REG_BUS-1:0] read_port(
        input logic                    re,
        input logic [REG_ADDR_BUS-1:0] raddr
    );
        logic [REG_BUS-1:0] val;
        val = ZERO_DWORD;
        if (!rst && state == ST_RUN && re == READ_ENABLE && raddr != '0) begin
            val = regs[raddr];
`ifdef REGFILE_BYPASS_EN
            if (we == WRITE_ENABLE && waddr == raddr)
                val = wdata;
`endif
        end
        return val;
    endfunction

    always_comb rdata1 = read_port(re1, raddr1);
    always_comb rdata2 = read_port(re2, raddr2);

endmodule
